// File: rtl/pwm_pkg.sv
// Shared constants, per-channel config type and the duty compare rule
// for the multichannel PWM block.
package pwm_pkg;

    localparam int PWM_NUM_CH = 16;
    localparam int PWM_CNT_W  = 8;
    localparam int PWM_PRE_W  = 8;

    // Static per-channel controls, gathered so the output stage reads as one unit.
    typedef struct packed {
        logic en_out;
        logic en_pwm;
        logic polarity;
    } ch_cfg_t;

    // Raw PWM level: an all-ones duty is a forced 100%, otherwise high while cnt < duty.
    // Operands are zero-extended to 32 bits; w is the real counter width (1..32).
    function automatic logic duty_hi(input logic [31:0] cnt,
                                     input logic [31:0] duty,
                                     input int          w);
        logic [31:0] all_ones;
        all_ones = 32'hFFFF_FFFF >> (32 - w);
        return (duty == all_ones) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_multichannel_if.sv
// Duty shadow-register write port. The register front end is the master.
interface pwm_multichannel_if #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             duty_wr_en;
    logic [CH_W-1:0]  duty_wr_ch;
    logic [CNT_W-1:0] duty_wr_data;

    modport master (
        output duty_wr_en,
        output duty_wr_ch,
        output duty_wr_data
    );

    modport slave (
        input duty_wr_en,
        input duty_wr_ch,
        input duty_wr_data
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler + period counter shared by all channels. Period and prescale are
// double-buffered: new values are only taken at a period boundary or restart.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int CNT_W = PWM_CNT_W,
    parameter int PRE_W = PWM_PRE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [CNT_W-1:0] period,
    input  logic [PRE_W-1:0] prescale,
    output logic [CNT_W-1:0] cnt,
    output logic             load,
    output logic             period_start
);

    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] act_prescale;
    logic [CNT_W-1:0] act_period;
    logic             tick;
    logic             boundary;

    // >= rather than == so a smaller value loaded mid-count can never overrun.
    assign tick     = (pre_cnt >= act_prescale);
    assign boundary = tick && (cnt >= act_period);

    // Active-register load strobe for the duty array in the top level.
    assign load = restart || boundary;

    // Counter state; restart beats a boundary, reset beats both.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            act_period   <= '1;
            act_prescale <= '0;
            period_start <= 1'b0;
        end else if (restart) begin
            pre_cnt      <= '0;
            cnt          <= '0;
            act_period   <= period;
            act_prescale <= prescale;
            period_start <= 1'b1;
        end else begin
            period_start <= boundary;
            if (tick) pre_cnt <= '0;
            else      pre_cnt <= pre_cnt + PRE_W'(1);
            if (boundary) begin
                cnt          <= '0;
                act_period   <= period;
                act_prescale <= prescale;
            end else if (tick) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// NUM_CH-channel PWM with per-channel duty, enables and polarity. Duty writes
// land in a shadow array and are copied to the active array at period
// boundaries so an output never sees a half-updated compare value.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int NUM_CH = PWM_NUM_CH,
    parameter int CNT_W  = PWM_CNT_W,
    parameter int PRE_W  = PWM_PRE_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_CH-1:0]  en_out,
    input  logic [NUM_CH-1:0]  en_pwm,
    input  logic [NUM_CH-1:0]  polarity,
    input  logic [CNT_W-1:0]   period,
    input  logic [PRE_W-1:0]   prescale,
    pwm_multichannel_if.slave  wr,
    input  logic               restart,
    output logic [NUM_CH-1:0]  out,
    output logic               period_start
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [NUM_CH-1:0][CNT_W-1:0] shadow_duty;
    logic [NUM_CH-1:0][CNT_W-1:0] act_duty;
    logic [NUM_CH-1:0]            out_nxt;
    logic [CNT_W-1:0]             cnt;
    logic                         load;
    logic                         wr_hit;

    pwm_timebase #(
        .CNT_W (CNT_W),
        .PRE_W (PRE_W)
    ) u_timebase (
        .clk          (clk),
        .rst_n        (rst_n),
        .restart      (restart),
        .period       (period),
        .prescale     (prescale),
        .cnt          (cnt),
        .load         (load),
        .period_start (period_start)
    );

    // Out-of-range channel indices (non power-of-two NUM_CH) are dropped.
    assign wr_hit = wr.duty_wr_en && (int'(wr.duty_wr_ch) < NUM_CH);

    // Shadow duty registers written from the front end at any time.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shadow_duty <= '0;
        end else if (wr_hit) begin
            shadow_duty[wr.duty_wr_ch] <= wr.duty_wr_data;
        end
    end

    // Active duty copies the shadow at a boundary/restart; a write on that
    // same edge is not seen until the following boundary.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            act_duty <= '0;
        end else if (load) begin
            act_duty <= shadow_duty;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        ch_cfg_t cfg;
        logic    hi;
        assign cfg = '{en_out: en_out[i], en_pwm: en_pwm[i], polarity: polarity[i]};
        assign hi  = duty_hi(32'(cnt), 32'(act_duty[i]), CNT_W);
        // Disabled output parks at the polarity level; en_pwm=0 holds it active.
        assign out_nxt[i] = (cfg.en_out ? (cfg.en_pwm ? hi : 1'b1) : 1'b0) ^ cfg.polarity;
    end

    // Registered pins, one clock behind the counter.
    always_ff @(posedge clk) begin
        if (!rst_n) out <= '0;
        else        out <= out_nxt;
    end

endmodule
